vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync_if.sv | 38 +++
 rtl/vga_sync.sv | 112 +++++++++++
 tb/tb_vga_sync.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
//------------------------------------------------------------------------------
// vga_sync_if : pixel-enable input and timing outputs of the VGA sync generator
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_sync_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_tick, frame_cnt
  );
  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, pixel_x, pixel_y, frame_tick, frame_cnt
  );
`else
  modport master (
    input  pix_en,
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_tick
  );
  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, pixel_x, pixel_y, frame_tick
  );
`endif
endinterface

`default_nettype wire

// File: rtl/vga_sync.sv
//------------------------------------------------------------------------------
// vga_sync : VGA raster counters with registered, zero-latency sync outputs.
//            Optional 8-bit frame counter enabled by macro VGA_SYNC_FRAME_CNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic       clk,
  input  logic       rst,
  vga_sync_if.master vif
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SW);

  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_tick_q, frame_tick_d;
  logic       frame_wrap;

  assign frame_wrap = vif.pix_en && (pixel_x_q == H_LAST) && (pixel_y_q == V_LAST);

  always_comb begin
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (vif.pix_en) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + 10'd1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end
    end
    // Decoded from the next count so the flags line up with the counters.
    hsync_d      = !((pixel_x_d >= H_SYNC_BEG) && (pixel_x_d < H_SYNC_END));
    vsync_d      = !((pixel_y_d >= V_SYNC_BEG) && (pixel_y_d < V_SYNC_END));
    video_on_d   = (pixel_x_d < H_VIS_END) && (pixel_y_d < V_VIS_END);
    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vif.pixel_x    = pixel_x_q;
  assign vif.pixel_y    = pixel_y_q;
  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.video_on   = video_on_q;
  assign vif.frame_tick = frame_tick_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Advances on the same edge that raises frame_tick.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
//------------------------------------------------------------------------------
// tb_vga_sync : directed self-checking bench; full-size instance for line
//               timing, reduced-size instance for whole-frame behaviour.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync;

  logic clk = 1'b1;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_cnt = 0;
  int   vs_low   = 0;

  always #5 clk = ~clk;

  vga_sync_if ifa ();
  vga_sync_if ifb ();

  vga_sync u_dut_a (
    .clk (clk),
    .rst (rst),
    .vif (ifa.master)
  );

  // Small raster: H_TOT = 15, V_TOT = 11, hsync low x=10..12, vsync low y=8..9.
  vga_sync #(
    .H_VIS (8), .H_FP (2), .H_SW (3), .H_BP (2),
    .V_VIS (6), .V_FP (2), .V_SW (2), .V_BP (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .vif (ifb.master)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pulse_a(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ifa.pix_en = 1'b1;
      @(posedge clk); #1;
      ifa.pix_en = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic pulse_b(input int n);
    for (int i = 0; i < n; i++) begin
      ifb.pix_en = 1'b1;
      @(posedge clk); #1;
      if (ifb.frame_tick) tick_cnt++;
      if (!ifb.vsync) vs_low++;
    end
    ifb.pix_en = 1'b0;
  endtask

  initial begin
    ifa.pix_en = 1'b0;
    ifb.pix_en = 1'b0;

    #20;
    check("rst_x",        int'(ifa.pixel_x),    0);
    check("rst_y",        int'(ifa.pixel_y),    0);
    check("rst_hsync",    int'(ifa.hsync),      1);
    check("rst_vsync",    int'(ifa.vsync),      1);
    check("rst_video_on", int'(ifa.video_on),   1);
    check("rst_tick",     int'(ifa.frame_tick), 0);
    check("rst_b_x",      int'(ifb.pixel_x),    0);
    check("rst_b_y",      int'(ifb.pixel_y),    0);
    #15 rst = 1'b1;
    @(posedge clk); #1;

    pulse_a(1, 3);
    check("first_pix_x", int'(ifa.pixel_x), 1);
    pulse_a(3, 3);
    check("p4_x",        int'(ifa.pixel_x),  4);
    check("p4_y",        int'(ifa.pixel_y),  0);
    check("p4_hsync",    int'(ifa.hsync),    1);
    check("p4_video_on", int'(ifa.video_on), 1);

    pulse_a(635, 0);
    check("x639_video_on", int'(ifa.video_on), 1);
    pulse_a(1, 0);
    check("x640_x",        int'(ifa.pixel_x),  640);
    check("x640_video_on", int'(ifa.video_on), 0);
    pulse_a(15, 0);
    check("x655_hsync", int'(ifa.hsync), 1);
    pulse_a(1, 0);
    check("x656_x",     int'(ifa.pixel_x), 656);
    check("x656_hsync", int'(ifa.hsync),   0);
    pulse_a(95, 0);
    check("x751_hsync", int'(ifa.hsync), 0);
    pulse_a(1, 0);
    check("x752_hsync", int'(ifa.hsync), 1);

    tick_cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ifa.frame_tick) tick_cnt++;
    end
    check("hold_x",        int'(ifa.pixel_x),  752);
    check("hold_y",        int'(ifa.pixel_y),  0);
    check("hold_hsync",    int'(ifa.hsync),    1);
    check("hold_video_on", int'(ifa.video_on), 0);
    check("hold_ticks",    tick_cnt,           0);

    pulse_a(48, 0);
    check("wrap_x",        int'(ifa.pixel_x),    0);
    check("wrap_y",        int'(ifa.pixel_y),    1);
    check("wrap_video_on", int'(ifa.video_on),   1);
    check("wrap_no_tick",  int'(ifa.frame_tick), 0);
    pulse_a(300, 0);
    check("a300_x", int'(ifa.pixel_x), 300);

    tick_cnt = 0;
    vs_low   = 0;
    pulse_b(119);
    check("b_14_7_x",     int'(ifb.pixel_x), 14);
    check("b_14_7_y",     int'(ifb.pixel_y), 7);
    check("b_14_7_vsync", int'(ifb.vsync),   1);
    pulse_b(1);
    check("b_0_8_vsync", int'(ifb.vsync), 0);
    pulse_b(29);
    check("b_14_9_vsync", int'(ifb.vsync), 0);
    pulse_b(1);
    check("b_0_10_vsync", int'(ifb.vsync), 1);
    pulse_b(14);
    check("b_line_ticks", tick_cnt, 0);
    check("b_vsync_len",  vs_low,   30);
    pulse_b(1);
    check("b_frame_x",        int'(ifb.pixel_x),    0);
    check("b_frame_y",        int'(ifb.pixel_y),    0);
    check("b_frame_tick",     int'(ifb.frame_tick), 1);
    check("b_frame_video_on", int'(ifb.video_on),   1);
    @(posedge clk); #1;
    check("b_tick_width", int'(ifb.frame_tick), 0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    check("frame_cnt_1", int'(ifb.frame_cnt), 1);
    for (int f = 2; f <= 256; f++) begin
      pulse_b(165);
      check("frame_cnt", int'(ifb.frame_cnt), f % 256);
    end
`endif

    pulse_b(100);
    check("b_10_6_x",        int'(ifb.pixel_x),  10);
    check("b_10_6_y",        int'(ifb.pixel_y),  6);
    check("b_10_6_hsync",    int'(ifb.hsync),    0);
    check("b_10_6_video_on", int'(ifb.video_on), 0);

    @(posedge clk); #3;
    rst = 1'b0;
    #2;
    check("arst_x",        int'(ifa.pixel_x),  0);
    check("arst_y",        int'(ifa.pixel_y),  0);
    check("arst_hsync",    int'(ifa.hsync),    1);
    check("arst_vsync",    int'(ifa.vsync),    1);
    check("arst_video_on", int'(ifa.video_on), 1);
    check("arst_b_x",      int'(ifb.pixel_x),  0);
    check("arst_b_y",      int'(ifb.pixel_y),  0);
    check("arst_b_hsync",  int'(ifb.hsync),    1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("arst_frame_cnt", int'(ifb.frame_cnt), 0);
`endif
    #20;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
